// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types and seven-segment constants for the mode sequencer
//
// Contents:
//   state_t      sequencer states RUN, CLEAR, GUARD, BANNER
//   SEG_*        single-digit glyphs; bit0=a .. bit6=g, bit7=dp, active-high
//   BANNER_ENC   "EnC     " frame, digit7 in [63:56]
//   BANNER_DEC   "dEC     " frame, digit7 in [63:56]
//   banner_frame returns the banner frame for a given mode bit
package morse_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        CLEAR  = 2'd1,
        GUARD  = 2'd2,
        BANNER = 2'd3
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_E     = 8'h79;  // a d e f g
    localparam logic [7:0] SEG_N     = 8'h54;  // c e g
    localparam logic [7:0] SEG_C     = 8'h39;  // a d e f
    localparam logic [7:0] SEG_D     = 8'h5E;  // b c d e g

    localparam logic [63:0] BANNER_ENC = {SEG_E, SEG_N, SEG_C, {5{SEG_BLANK}}};
    localparam logic [63:0] BANNER_DEC = {SEG_D, SEG_E, SEG_C, {5{SEG_BLANK}}};

    // Mode 0 is encode, mode 1 is decode.
    function automatic logic [63:0] banner_frame(input logic mode_bit);
        return mode_bit ? BANNER_DEC : BANNER_ENC;
    endfunction

endpackage

// File: rtl/rise_pulse.sv
// rtl/rise_pulse.sv - registered 1-bit rising-edge detector
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous reset, active-low
//   d_i      level input, already synchronous to clk
//   pulse_o  registered 1-cycle pulse, high the cycle after d_i is first seen high
//
// History resets to 0, so an input already high when reset releases still
// yields exactly one pulse.
module rise_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic pulse_o
);

    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= d_i;
            pulse_q <= d_i & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - encode/decode mode controller with clear/guard/banner sequencing
//
// Parameters:
//   GUARD_CYCLES   input blackout length after a mode change (>=1)
//   BANNER_CYCLES  banner display length (>=1)
//   CNT_W          shared counter width, 2**CNT_W > max(GUARD_CYCLES, BANNER_CYCLES)
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   mode_req, key_flag, bksp        level inputs, each rising edge is one event
//   key_value                       keypad code, valid while key_flag is high
//   enc_seg, dec_seg                datapath display frames
//   mode                            0 = encode, 1 = decode
//   key_out                         key code registered with the key strobe
//   enc_/dec_key_vld, _bksp, _clr   1-cycle strobes to the active datapath
//   seg_frame                       registered frame to the segment scanner
//   busy                            high whenever the sequencer is not in RUN
// Build option:
//   MODE_SEQ_KEYHOLD_EN  keeps the first key seen during GUARD/BANNER and
//                        delivers it to the new datapath on return to RUN.
module mode_sequencer
    import morse_pkg::*;
#(
    parameter int GUARD_CYCLES  = 100_000,
    parameter int BANNER_CYCLES = 50_000_000,
    parameter int CNT_W         = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_req,
    input  logic        key_flag,
    input  logic [3:0]  key_value,
    input  logic        bksp,
    input  logic [63:0] enc_seg,
    input  logic [63:0] dec_seg,
    output logic        mode,
    output logic [3:0]  key_out,
    output logic        enc_key_vld,
    output logic        dec_key_vld,
    output logic        enc_bksp,
    output logic        dec_bksp,
    output logic        enc_clr,
    output logic        dec_clr,
    output logic [63:0] seg_frame,
    output logic        busy
);

    logic mode_pulse;
    logic key_pulse;
    logic bksp_pulse;

    rise_pulse u_mode_edge (.clk(clk), .rst_n(rst), .d_i(mode_req), .pulse_o(mode_pulse));
    rise_pulse u_key_edge  (.clk(clk), .rst_n(rst), .d_i(key_flag), .pulse_o(key_pulse));
    rise_pulse u_bksp_edge (.clk(clk), .rst_n(rst), .d_i(bksp),     .pulse_o(bksp_pulse));

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         key_out_q, key_out_d;
    logic               enc_key_vld_q, enc_key_vld_d;
    logic               dec_key_vld_q, dec_key_vld_d;
    logic               enc_bksp_q, enc_bksp_d;
    logic               dec_bksp_q, dec_bksp_d;
    logic               enc_clr_q, enc_clr_d;
    logic               dec_clr_q, dec_clr_d;
    logic [63:0]        seg_q, seg_d;
    logic               busy_q, busy_d;

    logic               key_fire;
    logic [3:0]         key_fire_val;

`ifdef MODE_SEQ_KEYHOLD_EN
    logic               hold_vld_q, hold_vld_d;
    logic [3:0]         hold_val_q, hold_val_d;
`endif

    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BANNER_LAST = CNT_W'(BANNER_CYCLES - 1);

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        cnt_d         = cnt_q;
        key_out_d     = key_out_q;
        enc_key_vld_d = 1'b0;
        dec_key_vld_d = 1'b0;
        enc_bksp_d    = 1'b0;
        dec_bksp_d    = 1'b0;
        enc_clr_d     = 1'b0;
        dec_clr_d     = 1'b0;
        key_fire      = 1'b0;
        key_fire_val  = key_value;
`ifdef MODE_SEQ_KEYHOLD_EN
        hold_vld_d    = hold_vld_q;
        hold_val_d    = hold_val_q;
`endif

        case (state_q)
            RUN: begin
`ifdef MODE_SEQ_KEYHOLD_EN
                // A held key goes out first; a key edge arriving in the same
                // cycle takes its place in the holder and follows next cycle.
                if (hold_vld_q) begin
                    key_fire     = 1'b1;
                    key_fire_val = hold_val_q;
                    hold_vld_d   = key_pulse;
                    hold_val_d   = key_value;
                end else begin
                    key_fire = key_pulse;
                end
`else
                key_fire = key_pulse;
`endif
                if (bksp_pulse) begin
                    enc_bksp_d = ~mode_q;
                    dec_bksp_d = mode_q;
                end
                // The clear strobe leaves together with the state change so
                // the outgoing datapath is cleared while mode still names it.
                if (mode_pulse) begin
                    state_d   = CLEAR;
                    enc_clr_d = ~mode_q;
                    dec_clr_d = mode_q;
                end
            end
            CLEAR: begin
                mode_d  = ~mode_q;
                cnt_d   = '0;
                state_d = GUARD;
`ifdef MODE_SEQ_KEYHOLD_EN
                hold_vld_d = 1'b0;
`endif
            end
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = BANNER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BANNER: begin
                if (cnt_q == BANNER_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

`ifdef MODE_SEQ_KEYHOLD_EN
        // Only the first key of a blackout is kept; later ones are dropped.
        if ((state_q == GUARD || state_q == BANNER) && key_pulse && !hold_vld_q) begin
            hold_vld_d = 1'b1;
            hold_val_d = key_value;
        end
`endif

        if (key_fire) begin
            key_out_d     = key_fire_val;
            enc_key_vld_d = ~mode_q;
            dec_key_vld_d = mode_q;
        end
    end

    // CLEAR and GUARD show the frame of whatever mode register currently holds.
    always_comb begin
        if (state_q == BANNER) begin
            seg_d = banner_frame(mode_q);
        end else begin
            seg_d = mode_q ? dec_seg : enc_seg;
        end
        busy_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            mode_q        <= 1'b0;
            cnt_q         <= '0;
            key_out_q     <= 4'h0;
            enc_key_vld_q <= 1'b0;
            dec_key_vld_q <= 1'b0;
            enc_bksp_q    <= 1'b0;
            dec_bksp_q    <= 1'b0;
            enc_clr_q     <= 1'b0;
            dec_clr_q     <= 1'b0;
            seg_q         <= 64'h0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            key_out_q     <= key_out_d;
            enc_key_vld_q <= enc_key_vld_d;
            dec_key_vld_q <= dec_key_vld_d;
            enc_bksp_q    <= enc_bksp_d;
            dec_bksp_q    <= dec_bksp_d;
            enc_clr_q     <= enc_clr_d;
            dec_clr_q     <= dec_clr_d;
            seg_q         <= seg_d;
            busy_q        <= busy_d;
        end
    end

`ifdef MODE_SEQ_KEYHOLD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_vld_q <= 1'b0;
            hold_val_q <= 4'h0;
        end else begin
            hold_vld_q <= hold_vld_d;
            hold_val_q <= hold_val_d;
        end
    end
`endif

    assign mode        = mode_q;
    assign key_out     = key_out_q;
    assign enc_key_vld = enc_key_vld_q;
    assign dec_key_vld = dec_key_vld_q;
    assign enc_bksp    = enc_bksp_q;
    assign dec_bksp    = dec_bksp_q;
    assign enc_clr     = enc_clr_q;
    assign dec_clr     = dec_clr_q;
    assign seg_frame   = seg_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// tb/tb_mode_sequencer.sv - self-checking bench for mode_sequencer (honours MODE_SEQ_KEYHOLD_EN)
module tb_mode_sequencer;

    localparam int G = 4;
    localparam int B = 8;
    localparam logic [63:0] EXP_ENC = 64'h79_54_39_00_00_00_00_00;
    localparam logic [63:0] EXP_DEC = 64'h5E_79_39_00_00_00_00_00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode_req = 1'b0;
    logic        key_flag = 1'b0;
    logic [3:0]  key_value = 4'h0;
    logic        bksp = 1'b0;
    logic [63:0] enc_seg = 64'h0;
    logic [63:0] dec_seg = 64'h0;
    logic        mode;
    logic [3:0]  key_out;
    logic        enc_key_vld, dec_key_vld, enc_bksp, dec_bksp, enc_clr, dec_clr;
    logic [63:0] seg_frame;
    logic        busy;

    mode_sequencer #(.GUARD_CYCLES(G), .BANNER_CYCLES(B), .CNT_W(26)) dut (
        .clk(clk), .rst(rst), .mode_req(mode_req), .key_flag(key_flag),
        .key_value(key_value), .bksp(bksp), .enc_seg(enc_seg), .dec_seg(dec_seg),
        .mode(mode), .key_out(key_out), .enc_key_vld(enc_key_vld),
        .dec_key_vld(dec_key_vld), .enc_bksp(enc_bksp), .dec_bksp(dec_bksp),
        .enc_clr(enc_clr), .dec_clr(dec_clr), .seg_frame(seg_frame), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a mode change accepted at edge s occupies edges s..s+G+B
    // (busy), flips mode at s+1 and shows the banner after edges s+G+2..s+G+B+1.
    longint      cyc, s;
    bit          seq_act, m_mode, mode_before, run_before, banner, deliver;
    bit          pk, pb, pm, dk, db, dm, hv;
    logic [3:0]  hval, dval;
    bit          e_mode, e_ek, e_dk, e_eb, e_db, e_ec, e_dc, e_busy;
    logic [3:0]  e_key;
    logic [63:0] e_seg;
    int          n_enc_key, n_dec_key, n_enc_clr, n_dec_clr;

    always @(posedge clk) begin
        if (!rst) begin
            cyc = 0; s = 0; seq_act = 0; m_mode = 0;
            pk = 0; pb = 0; pm = 0; dk = 0; db = 0; dm = 0; hv = 0; hval = 0;
            e_mode = 0; e_key = 0; e_ek = 0; e_dk = 0; e_eb = 0; e_db = 0;
            e_ec = 0; e_dc = 0; e_busy = 0; e_seg = 0;
        end else begin
            cyc++;
            run_before  = !(seq_act && (cyc - 1 >= s) && (cyc - 1 <= s + G + B));
            mode_before = m_mode;
            e_ek = 0; e_dk = 0; e_eb = 0; e_db = 0; e_ec = 0; e_dc = 0;
            deliver = 0;
            dval = key_value;
            if (run_before) begin
`ifdef MODE_SEQ_KEYHOLD_EN
                if (hv) begin
                    deliver = 1; dval = hval; hv = dk; hval = key_value;
                end else begin
                    deliver = dk;
                end
`else
                deliver = dk;
`endif
                if (db) begin
                    if (mode_before) e_db = 1; else e_eb = 1;
                end
                if (dm) begin
                    seq_act = 1; s = cyc;
                    if (mode_before) e_dc = 1; else e_ec = 1;
                end
            end
`ifdef MODE_SEQ_KEYHOLD_EN
            else if (cyc - 1 == s) begin
                hv = 0;
            end else if (dk && !hv) begin
                hv = 1; hval = key_value;
            end
`endif
            if (deliver) begin
                e_key = dval;
                if (mode_before) e_dk = 1; else e_ek = 1;
            end
            if (seq_act && cyc == s + 1) m_mode = ~m_mode;
            e_mode = m_mode;
            e_busy = seq_act && (cyc >= s) && (cyc <= s + G + B);
            banner = seq_act && (cyc - 1 >= s + 1 + G) && (cyc - 1 <= s + G + B);
            e_seg  = banner ? (mode_before ? EXP_DEC : EXP_ENC)
                            : (mode_before ? dec_seg : enc_seg);
            dk = key_flag & ~pk; pk = key_flag;
            db = bksp & ~pb;     pb = bksp;
            dm = mode_req & ~pm; pm = mode_req;
        end
        #1;
        check("mode", mode, e_mode);
        check("key_out", key_out, e_key);
        check("enc_key_vld", enc_key_vld, e_ek);
        check("dec_key_vld", dec_key_vld, e_dk);
        check("enc_bksp", enc_bksp, e_eb);
        check("dec_bksp", dec_bksp, e_db);
        check("enc_clr", enc_clr, e_ec);
        check("dec_clr", dec_clr, e_dc);
        check("seg_frame", seg_frame, e_seg);
        check("busy", busy, e_busy);
        n_enc_key += int'(enc_key_vld);
        n_dec_key += int'(dec_key_vld);
        n_enc_clr += int'(enc_clr);
        n_dec_clr += int'(dec_clr);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int  snap, snap2, nbusy, nban;
    bit  seen;

    initial begin
        n_enc_key = 0; n_dec_key = 0; n_enc_clr = 0; n_dec_clr = 0;
        enc_seg = {$urandom, $urandom};
        dec_seg = {$urandom, $urandom};
        #1;
        check("rst_mode", mode, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_seg", seg_frame, 64'h0);
        check("rst_key_out", key_out, 4'h0);
        step(3);
        rst = 1'b1;
        step(2);

        // 1: single key in encode mode
        key_value = 4'h5; key_flag = 1'b1;
        step(3);
        key_flag = 1'b0;
        step(3);
        check("t1_enc_key_cnt", n_enc_key, 1);
        check("t1_dec_key_cnt", n_dec_key, 0);
        check("t1_key_out", key_out, 4'h5);

        // 2 + 5a: mode change, with a second request during BANNER
        snap = n_enc_clr; snap2 = n_dec_clr;
        nbusy = 0; nban = 0;
        mode_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (seg_frame === EXP_DEC) nban++;
            if (i == 2)  mode_req = 1'b0;
            if (i == 9)  mode_req = 1'b1;
            if (i == 11) mode_req = 1'b0;
        end
        check("t2_enc_clr_cnt", n_enc_clr - snap, 1);
        check("t2_busy_cycles", nbusy, 13);
        check("t2_banner_cycles", nban, 8);
        check("t2_mode", mode, 1'b1);
        check("t2_seg_after", seg_frame, dec_seg);
        check("t5_no_dec_clr", n_dec_clr - snap2, 0);

        // 5b: request in RUN returns to encode
        snap = n_dec_clr;
        mode_req = 1'b1; step(3); mode_req = 1'b0; step(20);
        check("t5_dec_clr_cnt", n_dec_clr - snap, 1);
        check("t5_mode", mode, 1'b0);

        // 3: key during GUARD of a change into decode
        snap = n_dec_key; snap2 = n_enc_key;
        mode_req = 1'b1; step(4);
        key_value = 4'hA; key_flag = 1'b1; step(2); key_flag = 1'b0;
        mode_req = 1'b0; step(20);
        check("t3_mode", mode, 1'b1);
        check("t3_enc_key_cnt", n_enc_key - snap2, 0);
`ifdef MODE_SEQ_KEYHOLD_EN
        check("t3_held_key_cnt", n_dec_key - snap, 1);
        check("t3_held_key_val", key_out, 4'hA);
`else
        check("t3_dropped_key_cnt", n_dec_key - snap, 0);
`endif

        // 4: long key hold, then key and bksp rising together
        snap = n_dec_key;
        key_value = 4'h3; key_flag = 1'b1; step(100); key_flag = 1'b0; step(3);
        check("t4_hold_one_strobe", n_dec_key - snap, 1);
        key_value = 4'hC; key_flag = 1'b1; bksp = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dec_key_vld && !seen) begin
                seen = 1;
                check("t4_pair_bksp", dec_bksp, 1'b1);
                check("t4_pair_key", key_out, 4'hC);
            end
        end
        check("t4_pair_seen", seen, 1'b1);
        key_flag = 1'b0; bksp = 1'b0; step(2);

        // 6: reset in GUARD
        mode_req = 1'b1; step(4); mode_req = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("t6_mode", mode, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_strobes", {enc_key_vld, dec_key_vld, enc_bksp, dec_bksp, enc_clr, dec_clr}, 6'b0);
        step(2);
        rst = 1'b1;
        step(3);
        check("t6_run_after", busy, 1'b0);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 8) begin
                key_flag = ~key_flag;
                if (key_flag) key_value = 4'($urandom);
            end
            if ($urandom_range(0, 99) < 8)  bksp = ~bksp;
            if ($urandom_range(0, 99) < 4)  mode_req = ~mode_req;
            if ($urandom_range(0, 99) < 10) enc_seg = {$urandom, $urandom};
            if ($urandom_range(0, 99) < 10) dec_seg = {$urandom, $urandom};
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0; step(2); rst = 1'b1;
            end
        end
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
